hub_message_router: RTL and testbench
=====================================

// Module: hub_message_router
// PURPOSE
//  Hub-side peer of each leaf's final_fifo_out/final_fifo_in link: terminates LEAF_COUNT leaf links and
//  routes every word to the leaf named in its destination FPGA-ID field.
//  Sits in the hub top; each leaf's final_fifo_out feeds a leaf_in port; each leaf_out port feeds that leaf's final_fifo_in.
//  Provides a flying-message flag so the root stage controller can detect global quiescence.
// PARAMETERS
//  LEAF_COUNT      4   number of leaf FPGAs; port i serves FPGA ID i+1 (hub is ID 0)
//  HUB_FIFO_WIDTH  32  link word width, identical to leaf HUB_FIFO_WIDTH
//  FPGAID_WIDTH    3   width of destination ID field, word[HUB_FIFO_WIDTH-1 -: FPGAID_WIDTH]
//  DROP_CNT_WIDTH  16  width of saturating drop counter
// PORTS
//  clk             in   1                        clock
//  reset           in   1                        async, active-high
//  leaf_in_data    in   LEAF_COUNT*HUB_FIFO_WIDTH  words from leaves, port i at [i*W +: W]
//  leaf_in_valid   in   LEAF_COUNT               per-port valid
//  leaf_in_ready   out  LEAF_COUNT               per-port ready (word consumed when valid&ready)
//  leaf_out_data   out  LEAF_COUNT*HUB_FIFO_WIDTH  words to leaves, port j at [j*W +: W]
//  leaf_out_valid  out  LEAF_COUNT               per-port valid
//  leaf_out_ready  in   LEAF_COUNT               per-port ready from leaf final_fifo_in_ready
//  has_message_flying out 1                      registered: any leaf_in_valid or leaf_out_valid last cycle
//  drop_count      out  DROP_CNT_WIDTH           saturating count of dropped (misaddressed) words
// BEHAVIOUR
//  - Reset (async, active-high): leaf_out_valid=0, leaf_out_data=0, all RR pointers=0, drop_count=0,
//    has_message_flying=0. Words held in output registers are discarded; mid-operation reset is legal.
//  - leaf_in_ready is combinational from current state and leaf_in_valid/leaf_out_ready; never depends on leaf_in_data of other ports beyond destination decode.
//  - Decode: dest = word[HUB_FIFO_WIDTH-1 -: FPGAID_WIDTH]; valid target iff 1 <= dest <= LEAF_COUNT -> output j=dest-1.
//    Loopback (dest == own ID) is routed normally. Word is forwarded unmodified (ID field kept).
//  - Invalid dest (0 or >LEAF_COUNT): leaf_in_ready=1 same cycle, word dropped, drop_count+=1 (saturates at all-ones);
//    multiple simultaneous drops add their count in one cycle, still saturating.
//  - Per output j: one registered slot. Slot "free" iff !leaf_out_valid[j] | leaf_out_ready[j].
//    If free and >=1 input requests j, grant exactly one by round-robin starting at rr_ptr[j];
//    granted input sees leaf_in_ready=1; slot loads word next edge (latency 1 cycle in->out).
//    rr_ptr[j] <= grant+1 (mod LEAF_COUNT) only on a grant. Losers and requests to a non-free slot see ready=0 and must hold.
//  - leaf_out_valid[j] falls only when drained with no new grant; back-to-back full throughput (1 word/cycle/output) required.
//  - Each input requests only one output (its head word), so no input is ever granted twice per cycle.
//  - Ordering: words from one input to one output leave in arrival order; no ordering across inputs.
//  - has_message_flying <= |leaf_in_valid | |leaf_out_valid (one-cycle registered).
// STRUCTURE
//  - hub_pkg: FPGAID field position function, dest_valid() helper, DROP_CNT saturation constant.
//  - Sub-module rr_arbiter #(N): req[N], ptr[$clog2(N)], grant one-hot + grant_idx; one instance per output.
//  - Top: decode per input, request matrix req[j][i], output slot registers, drop counter, flying flag.
// TESTING (LEAF_COUNT=4, W=32, FPGAID_WIDTH=3)
//  - Single hop: in0 sends 0x4000_00AB (dest 2) -> out1 valid next cycle, data 0x4000_00AB; in0 ready same cycle as valid.
//  - Contention: in0,in1,in2 all send to dest 4 continuously, out3 ready=1 -> out3 carries in0,in1,in2,in0,... one per cycle.
//  - Backpressure: out1 ready=0 with slot full -> in0 ready=0, word held; raise ready -> delivered next cycle, no duplicate/loss.
//  - Misaddressed: in2 sends dest 0 and dest 7 -> both accepted immediately, no leaf_out_valid, drop_count=2; force 0xFFFF -> stays 0xFFFF.
//  - Reset mid-traffic: assert reset with out slots full -> all valid=0, drop_count=0, flying=0 asynchronously; traffic resumes after release.
//  - Random soak: all 4 inputs random dests/valid, random out ready -> scoreboard per (src,dst) FIFO order, flying=0 two cycles after idle.

Source files
------------

// File: rtl/hub_message_router_pkg.sv
// Shared constants and helpers for the hub message router:
// default parameter values, pointer sizing, ID field position and destination decode.
package hub_message_router_pkg;

    localparam int LEAF_COUNT_DEF     = 4;
    localparam int HUB_FIFO_WIDTH_DEF = 32;
    localparam int FPGAID_WIDTH_DEF   = 3;
    localparam int DROP_CNT_WIDTH_DEF = 16;

    // Width of an index into n things; never zero so single-leaf builds still elaborate.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // LSB of the destination FPGA-ID field; the field occupies the top id_w bits of the word.
    function automatic int id_lsb(input int word_w, input int id_w);
        return word_w - id_w;
    endfunction

    // Leaves are IDs 1..leaf_count; ID 0 is the hub itself and anything above is unrouted.
    function automatic logic dest_valid(input int unsigned dest, input int unsigned leaf_count);
        return (dest >= 32'd1) && (dest <= leaf_count);
    endfunction

endpackage

// File: rtl/hub_message_router_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found scanning upward (with wrap)
// from ptr_i. Purely combinational; the caller owns and advances the pointer.
module rr_arbiter
    import hub_message_router_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] grant_idx_o
);

    int   idx;
    logic found;

    // Scan requesters starting at the pointer; first hit wins, later hits are ignored.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/hub_message_router.sv
// Hub-side router for the leaf links: each input word is steered to the output
// named by its destination FPGA-ID field, misaddressed words are dropped and
// counted, and a registered flag reports whether anything is still in flight.
module hub_message_router
    import hub_message_router_pkg::*;
#(
    parameter int LEAF_COUNT     = LEAF_COUNT_DEF,
    parameter int HUB_FIFO_WIDTH = HUB_FIFO_WIDTH_DEF,
    parameter int FPGAID_WIDTH   = FPGAID_WIDTH_DEF,
    parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [LEAF_COUNT*HUB_FIFO_WIDTH-1:0] leaf_in_data,
    input  logic [LEAF_COUNT-1:0]                leaf_in_valid,
    output logic [LEAF_COUNT-1:0]                leaf_in_ready,
    output logic [LEAF_COUNT*HUB_FIFO_WIDTH-1:0] leaf_out_data,
    output logic [LEAF_COUNT-1:0]                leaf_out_valid,
    input  logic [LEAF_COUNT-1:0]                leaf_out_ready,
    output logic                                 has_message_flying,
    output logic [DROP_CNT_WIDTH-1:0]            drop_count
);

    localparam int N      = LEAF_COUNT;
    localparam int W      = HUB_FIFO_WIDTH;
    localparam int IW     = FPGAID_WIDTH;
    localparam int PW     = ptr_width(N);
    localparam int ID_LSB = id_lsb(W, IW);
    // Sum width leaves headroom for one cycle's worth of drops on top of a full counter.
    localparam int SW     = DROP_CNT_WIDTH + ptr_width(N + 1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_SAT = '1;

    logic [N-1:0][IW-1:0]     dest;
    logic [N-1:0]             routable;
    logic [N-1:0]             drop;
    logic [N-1:0]             slot_free;
    logic [N-1:0][N-1:0]      req;       // req[j][i]: input i wants output j and j can take it
    logic [N-1:0][N-1:0]      gnt;       // gnt[j][i]: output j accepts input i this cycle
    logic [N-1:0][PW-1:0]     gnt_idx;

    logic [N-1:0]             out_valid_q, out_valid_d;
    logic [N-1:0][W-1:0]      out_data_q,  out_data_d;
    logic [N-1:0][PW-1:0]     rr_q,        rr_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                     flying_q;
    logic [SW-1:0]            ndrop;
    logic [SW-1:0]            drop_sum;

    // Decode each input's destination and split routable words from ones to discard.
    always_comb begin
        dest     = '0;
        routable = '0;
        drop     = '0;
        for (int i = 0; i < N; i++) begin
            dest[i]     = leaf_in_data[i*W + ID_LSB +: IW];
            routable[i] = leaf_in_valid[i] &&  dest_valid(32'(dest[i]), N);
            drop[i]     = leaf_in_valid[i] && !dest_valid(32'(dest[i]), N);
        end
    end

    // Build the request matrix; a busy, stalled slot presents no requests so it grants nothing.
    always_comb begin
        req       = '0;
        slot_free = '0;
        for (int j = 0; j < N; j++) begin
            slot_free[j] = !out_valid_q[j] || leaf_out_ready[j];
            for (int i = 0; i < N; i++) begin
                req[j][i] = slot_free[j] && routable[i] && (32'(dest[i]) == 32'(j + 1));
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_arb
        rr_arbiter #(.N(N), .PW(PW)) u_arb (
            .req_i       (req[j]),
            .ptr_i       (rr_q[j]),
            .grant_o     (gnt[j]),
            .grant_idx_o (gnt_idx[j])
        );
    end

    // Next state of output slots, pointers and ready; a draining slot reloads in the same cycle.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        rr_d          = rr_q;
        leaf_in_ready = drop;
        for (int j = 0; j < N; j++) begin
            leaf_in_ready = leaf_in_ready | gnt[j];
            if (slot_free[j]) begin
                out_valid_d[j] = |gnt[j];
                if (|gnt[j]) begin
                    out_data_d[j] = leaf_in_data[int'(gnt_idx[j])*W +: W];
                    if (int'(gnt_idx[j]) == N - 1) rr_d[j] = '0;
                    else                           rr_d[j] = gnt_idx[j] + PW'(1);
                end
            end
        end
    end

    // Add every drop seen this cycle, clamping at all-ones.
    always_comb begin
        ndrop = '0;
        for (int i = 0; i < N; i++) begin
            ndrop = ndrop + SW'(drop[i]);
        end
        drop_sum   = SW'(drop_cnt_q) + ndrop;
        drop_cnt_d = (drop_sum > SW'(DROP_SAT)) ? DROP_SAT : drop_sum[DROP_CNT_WIDTH-1:0];
    end

    // State registers; reset discards anything held in the output slots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            rr_q        <= '0;
            drop_cnt_q  <= '0;
            flying_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_q        <= rr_d;
            drop_cnt_q  <= drop_cnt_d;
            flying_q    <= (|leaf_in_valid) | (|out_valid_q);
        end
    end

    assign leaf_out_valid     = out_valid_q;
    assign leaf_out_data      = out_data_q;
    assign drop_count         = drop_cnt_q;
    assign has_message_flying = flying_q;

endmodule

// File: tb/tb_hub_message_router.sv
// Bench for hub_message_router: directed scenarios plus a random soak checked
// against a cycle-level behavioural model and a per-(src,dst) ordering scoreboard.
module tb_hub_message_router;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int DCW = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N*W-1:0]   leaf_in_data = '0;
    logic [N-1:0]     leaf_in_valid = '0;
    logic [N-1:0]     leaf_in_ready;
    logic [N*W-1:0]   leaf_out_data;
    logic [N-1:0]     leaf_out_valid;
    logic [N-1:0]     leaf_out_ready = '1;
    logic             has_message_flying;
    logic [DCW-1:0]   drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    hub_message_router #(.LEAF_COUNT(N), .HUB_FIFO_WIDTH(W), .FPGAID_WIDTH(3), .DROP_CNT_WIDTH(DCW)) dut (
        .clk                (clk),
        .reset              (reset),
        .leaf_in_data       (leaf_in_data),
        .leaf_in_valid      (leaf_in_valid),
        .leaf_in_ready      (leaf_in_ready),
        .leaf_out_data      (leaf_out_data),
        .leaf_out_valid     (leaf_out_valid),
        .leaf_out_ready     (leaf_out_ready),
        .has_message_flying (has_message_flying),
        .drop_count         (drop_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-output slot contents, last winner per output, drop tally, flying flag.
    logic [N-1:0]        m_vld;
    logic [N-1:0][W-1:0] m_data;
    int                  m_last [N];
    int                  m_win  [N];
    logic [N-1:0]        m_rdy;
    int                  m_ndrop;
    int                  m_drop;
    logic                m_fly;

    task automatic model_reset();
        m_vld = '0; m_data = '0; m_drop = 0; m_fly = 1'b0;
        for (int j = 0; j < N; j++) m_last[j] = N - 1;
    endtask

    function automatic int dest_of(input int i);
        logic [2:0] d;
        d = leaf_in_data[i*W + 29 +: 3];
        return int'(d);
    endfunction

    // Who may go this cycle: misaddressed words always; otherwise the next requester after the last winner.
    task automatic model_arbitrate();
        m_rdy = '0; m_ndrop = 0;
        for (int i = 0; i < N; i++)
            if (leaf_in_valid[i] && (dest_of(i) == 0 || dest_of(i) > N)) begin
                m_rdy[i] = 1'b1; m_ndrop++;
            end
        for (int j = 0; j < N; j++) begin
            m_win[j] = -1;
            if (!m_vld[j] || leaf_out_ready[j])
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last[j] + k) % N;
                    if (m_win[j] < 0 && leaf_in_valid[i] && dest_of(i) == j + 1) m_win[j] = i;
                end
            if (m_win[j] >= 0) m_rdy[m_win[j]] = 1'b1;
        end
    endtask

    task automatic model_clock();
        m_fly  = (|leaf_in_valid) || (|m_vld);
        m_drop = (m_drop + m_ndrop > 65535) ? 65535 : m_drop + m_ndrop;
        for (int j = 0; j < N; j++) begin
            if (!m_vld[j] || leaf_out_ready[j]) begin
                if (m_win[j] >= 0) begin
                    m_vld[j]  = 1'b1;
                    m_data[j] = leaf_in_data[m_win[j]*W +: W];
                    m_last[j] = m_win[j];
                end else begin
                    m_vld[j] = 1'b0;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        leaf_in_valid = '0; leaf_in_data = '0; leaf_out_ready = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (leaf_out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", leaf_out_valid); end
        n_checks++; if (leaf_out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", leaf_out_data); end
        n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop: got %h want 0", drop_count); end
        n_checks++; if (has_message_flying !== 1'b0) begin n_fail++; $display("FAIL reset_flying: got %b want 0", has_message_flying); end
        n_checks++; if (leaf_in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", leaf_in_ready); end
        do_reset();
    endtask

    task automatic test_single_hop();
        do_reset();
        leaf_in_valid = 4'b0001;
        leaf_in_data[31:0] = 32'h4000_00AB;
        #1;
        n_checks++; if (leaf_in_ready !== 4'b0001) begin n_fail++; $display("FAIL hop_ready: got %b want 0001", leaf_in_ready); end
        @(posedge clk); #1;
        n_checks++; if (leaf_out_valid !== 4'b0010) begin n_fail++; $display("FAIL hop_valid: got %b want 0010", leaf_out_valid); end
        n_checks++; if (leaf_out_data[63:32] !== 32'h4000_00AB) begin n_fail++; $display("FAIL hop_data: got %h want 400000ab", leaf_out_data[63:32]); end
        n_checks++; if (has_message_flying !== 1'b1) begin n_fail++; $display("FAIL hop_fly1: got %b want 1", has_message_flying); end
        leaf_in_valid = '0;
        @(posedge clk); #1;
        n_checks++; if (leaf_out_valid !== 4'b0000) begin n_fail++; $display("FAIL hop_drain: got %b want 0000", leaf_out_valid); end
        n_checks++; if (has_message_flying !== 1'b1) begin n_fail++; $display("FAIL hop_fly2: got %b want 1", has_message_flying); end
        @(posedge clk); #1;
        n_checks++; if (has_message_flying !== 1'b0) begin n_fail++; $display("FAIL hop_fly_idle: got %b want 0", has_message_flying); end
    endtask

    task automatic test_contention();
        do_reset();
        leaf_in_valid = 4'b0111;
        for (int i = 0; i < 3; i++) leaf_in_data[i*W +: W] = 32'h8000_00A0 + 32'(i);
        for (int k = 0; k < 6; k++) begin
            logic [N-1:0] er;
            er = 4'(1 << (k % 3));
            #1;
            n_checks++; if (leaf_in_ready !== er) begin n_fail++; $display("FAIL cont_ready[%0d]: got %b want %b", k, leaf_in_ready, er); end
            @(posedge clk); #1;
            n_checks++; if (leaf_out_valid !== 4'b1000) begin n_fail++; $display("FAIL cont_valid[%0d]: got %b want 1000", k, leaf_out_valid); end
            n_checks++; if (leaf_out_data[127:96] !== 32'h8000_00A0 + 32'(k % 3)) begin
                n_fail++; $display("FAIL cont_data[%0d]: got %h want %h", k, leaf_out_data[127:96], 32'h8000_00A0 + 32'(k % 3)); end
        end
        leaf_in_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        leaf_out_ready = 4'b1101;
        leaf_in_valid = 4'b0001;
        leaf_in_data[31:0] = 32'h4000_0001;
        #1;
        n_checks++; if (leaf_in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first_ready: got %b want 0001", leaf_in_ready); end
        @(posedge clk); #1;
        leaf_in_data[31:0] = 32'h4000_0002;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (leaf_in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, leaf_in_ready); end
            @(posedge clk); #1;
            n_checks++; if (leaf_out_valid !== 4'b0010 || leaf_out_data[63:32] !== 32'h4000_0001) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h want 0010/40000001", k, leaf_out_valid, leaf_out_data[63:32]); end
        end
        leaf_out_ready = '1;
        #1;
        n_checks++; if (leaf_in_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0001", leaf_in_ready); end
        @(posedge clk); #1;
        n_checks++; if (leaf_out_valid !== 4'b0010 || leaf_out_data[63:32] !== 32'h4000_0002) begin
            n_fail++; $display("FAIL bp_second: got %b/%h want 0010/40000002", leaf_out_valid, leaf_out_data[63:32]); end
        leaf_in_valid = '0;
        @(posedge clk); #1;
        n_checks++; if (leaf_out_valid !== 4'b0000) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0000", leaf_out_valid); end
    endtask

    task automatic test_misaddressed();
        do_reset();
        leaf_in_valid = 4'b0100;
        leaf_in_data[95:64] = 32'h0000_0055;
        #1;
        n_checks++; if (leaf_in_ready !== 4'b0100) begin n_fail++; $display("FAIL mis_ready0: got %b want 0100", leaf_in_ready); end
        @(posedge clk); #1;
        leaf_in_data[95:64] = 32'hE000_0066;
        #1;
        n_checks++; if (leaf_in_ready !== 4'b0100) begin n_fail++; $display("FAIL mis_ready7: got %b want 0100", leaf_in_ready); end
        @(posedge clk); #1;
        leaf_in_valid = '0;
        n_checks++; if (leaf_out_valid !== 4'b0000) begin n_fail++; $display("FAIL mis_valid: got %b want 0000", leaf_out_valid); end
        n_checks++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL mis_count: got %0d want 2", drop_count); end
        // Flood all four inputs with hub-addressed words to push the counter into saturation.
        for (int i = 0; i < N; i++) leaf_in_data[i*W +: W] = 32'h1FFF_FFF0 + 32'(i);
        leaf_in_valid = '1;
        repeat (16383) @(posedge clk);
        #1;
        n_checks++; if (drop_count !== 16'hFFFE) begin n_fail++; $display("FAIL mis_near_sat: got %h want fffe", drop_count); end
        @(posedge clk); #1;
        n_checks++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL mis_sat: got %h want ffff", drop_count); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL mis_sat_hold: got %h want ffff", drop_count); end
        n_checks++; if (leaf_out_valid !== 4'b0000) begin n_fail++; $display("FAIL mis_flood_valid: got %b want 0000", leaf_out_valid); end
        leaf_in_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        leaf_in_valid = 4'b0001;
        leaf_in_data[31:0] = 32'h0000_0011;
        @(posedge clk); #1;
        leaf_out_ready = '0;
        leaf_in_valid = '1;
        for (int i = 0; i < N; i++) leaf_in_data[i*W +: W] = (32'(i + 1) << 29) | (32'h100 + 32'(i));
        #1;
        n_checks++; if (leaf_in_ready !== 4'b1111) begin n_fail++; $display("FAIL rst_fill_ready: got %b want 1111", leaf_in_ready); end
        @(posedge clk); #1;
        n_checks++; if (leaf_out_valid !== 4'b1111 || drop_count !== 16'd1) begin
            n_fail++; $display("FAIL rst_full: got %b/%0d want 1111/1", leaf_out_valid, drop_count); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (leaf_out_valid !== 4'b0000 || leaf_out_data !== '0) begin
            n_fail++; $display("FAIL rst_async_slots: got %b/%h want 0000/0", leaf_out_valid, leaf_out_data); end
        n_checks++; if (drop_count !== 16'd0 || has_message_flying !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_misc: got %0d/%b want 0/0", drop_count, has_message_flying); end
        @(negedge clk);
        reset = 1'b0;
        leaf_out_ready = '1;
        leaf_in_valid = 4'b0001;
        leaf_in_data[31:0] = 32'h6000_0077;
        #1;
        n_checks++; if (leaf_in_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_resume_ready: got %b want 0001", leaf_in_ready); end
        @(posedge clk); #1;
        n_checks++; if (leaf_out_valid !== 4'b0100 || leaf_out_data[95:64] !== 32'h6000_0077) begin
            n_fail++; $display("FAIL rst_resume_out: got %b/%h want 0100/60000077", leaf_out_valid, leaf_out_data[95:64]); end
        leaf_in_valid = '0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_random_soak();
        logic [N-1:0] v;
        logic [W-1:0] cur [N];
        int seq [N];
        int last_seq [N*N];
        int sent, delivered, idle_at;
        do_reset();
        v = '0; sent = 0; delivered = 0;
        for (int i = 0; i < N; i++) begin seq[i] = 0; cur[i] = '0; end
        for (int p = 0; p < N*N; p++) last_seq[p] = -1;
        for (int c = 0; c < 3012; c++) begin
            for (int i = 0; i < N; i++)
                if (!v[i] && c < 3000 && $urandom_range(0, 9) < 6) begin
                    int r, d;
                    r = int'($urandom_range(0, 9));
                    d = (r < 8) ? (r % 4) + 1 : (r == 8 ? 0 : int'($urandom_range(5, 7)));
                    cur[i] = {3'(d), 23'(seq[i]), 6'(i)};
                    seq[i]++;
                    v[i] = 1'b1;
                end
            for (int j = 0; j < N; j++) leaf_out_ready[j] = (c >= 3000) || ($urandom_range(0, 9) < 7);
            leaf_in_valid = v;
            for (int i = 0; i < N; i++) leaf_in_data[i*W +: W] = cur[i];
            #1;
            model_arbitrate();
            n_checks++; if (leaf_in_ready !== m_rdy) begin n_fail++; $display("FAIL soak_ready@%0d: got %b want %b", c, leaf_in_ready, m_rdy); end
            for (int j = 0; j < N; j++)
                if (leaf_out_valid[j] && leaf_out_ready[j]) begin
                    logic [W-1:0] w;
                    int s, q;
                    w = leaf_out_data[j*W +: W];
                    s = int'(w[5:0]); q = int'(w[28:6]);
                    n_checks++;
                    if (s >= N || int'(w[31:29]) != j + 1 || q <= last_seq[(s % N)*N + j]) begin
                        n_fail++; $display("FAIL soak_order@%0d out%0d: got word %h after seq %0d", c, j, w, last_seq[(s % N)*N + j]);
                    end else last_seq[s*N + j] = q;
                    delivered++;
                end
            @(posedge clk);
            model_clock();
            for (int i = 0; i < N; i++)
                if (v[i] && m_rdy[i]) begin
                    if (dest_of(i) >= 1 && dest_of(i) <= N) sent++;
                    v[i] = 1'b0;
                end
            #1;
            n_checks++; if (leaf_out_valid !== m_vld || leaf_out_data !== m_data) begin
                n_fail++; $display("FAIL soak_out@%0d: got %b/%h want %b/%h", c, leaf_out_valid, leaf_out_data, m_vld, m_data); end
            n_checks++; if (has_message_flying !== m_fly || drop_count !== 16'(m_drop)) begin
                n_fail++; $display("FAIL soak_misc@%0d: got %b/%0d want %b/%0d", c, has_message_flying, drop_count, m_fly, m_drop); end
        end
        // Everything has drained; two idle edges later the flag must be clear.
        leaf_in_valid = '0;
        idle_at = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (v !== 4'b0000 || leaf_out_valid !== 4'b0000 || has_message_flying !== 1'b0) begin
            n_fail++; $display("FAIL soak_idle: got pend %b valid %b fly %b want 0000/0000/0", v, leaf_out_valid, has_message_flying); end
        n_checks++; if (delivered != sent || sent == idle_at) begin
            n_fail++; $display("FAIL soak_count: got delivered %0d want sent %0d (nonzero)", delivered, sent); end
    endtask

    initial begin
        test_reset();
        test_single_hop();
        test_contention();
        test_backpressure();
        test_misaddressed();
        test_reset_mid();
        test_random_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
